image_draw_ctl: RTL and testbench
=================================

Name: image_draw_ctl

Overview:
- Sequences a synchronous image ROM (16-bit address {addry[7:0], addrx[7:0]}, 12-bit RGB, 1-cycle read latency) to overlay an IMG_W x IMG_H sprite onto the VGA pixel stream at (xpos, ypos).
- Sits between the timing/background chain and the next overlay stage.
- Generates ROM addresses, delays the timing signals to match ROM latency, and runs a frame-synchronous visibility FSM (hidden/shown/blink) for menu buttons.

Parameters:
- IMG_W, 128, sprite width in pixels, range 1..256
- IMG_H, 64, sprite height in pixels, range 1..256
- BLINK_FRAMES, 30, frames per blink half-period, range 1..255

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing signals
- rgb_in  in  12  background pixel
- xpos  in  12  sprite left column (unsigned)
- ypos  in  12  sprite top row (unsigned)
- show  in  1  request sprite visible
- blink  in  1  request blinking (valid only with show=1)
- rgb_pixel  in  12  ROM data, valid 1 cycle after address
- address  out  16  ROM address {addry[7:0], addrx[7:0]}
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel
- visible  out  1  current-frame visibility flag

Behaviour:
- Reset: all outputs 0; FSM in HIDDEN; latched position 0; frame counter 0; visible=0.
- Frame sync: frame_tick = rising edge of vblnk_in (vblnk_in=1, registered previous value=0). xpos, ypos, show and blink are sampled only on frame_tick. Mid-frame input changes take effect next frame (no tearing).
- FSM, evaluated on frame_tick only:
  - HIDDEN: show=1 & blink=0 -> SHOWN; show=1 & blink=1 -> BLINK with counter cleared and phase=on.
  - SHOWN: show=0 -> HIDDEN; blink=1 -> BLINK with counter cleared and phase=on.
  - BLINK: show=0 -> HIDDEN; blink=0 -> SHOWN. Otherwise the counter increments; when it reaches BLINK_FRAMES-1 it clears and phase toggles.
  - visible = SHOWN | (BLINK & phase=on); updated on the same frame_tick.
- Stage 1, registered:
  - dx = hcount_in - x_lat and dy = vcount_in - y_lat, computed 12-bit.
  - inside = (hcount_in >= x_lat) & (hcount_in < x_lat+IMG_W) & (vcount_in >= y_lat) & (vcount_in < y_lat+IMG_H), compared at 13 bits (no wrap).
  - address <= {dy[7:0], dx[7:0]} when inside, else 16'h0000.
  - Timing signals and rgb_in are registered alongside.
- Stage 2, registered: all timing signals are delayed again.
  - rgb_out = 12'h000 if hblnk|vblnk.
  - Else rgb_pixel if inside_d & visible.
  - Else rgb_in_d.
- Total latency in -> out: exactly 2 cycles for every timing signal, counter and rgb_out.
- Partially off-screen sprite (e.g. xpos=1000): only the on-screen portion is drawn, with no wrap to column 0.
- Sprite touching the last column or row: the final pixel is drawn, nothing beyond it.
- Reset asserted mid-frame: outputs go to 0 on the next edge; the FSM returns to HIDDEN until the next frame_tick after release.
- frame_tick coinciding with a pixel inside the sprite: the new latched values apply from the following cycle.

Optional Feature:
- Macro: IMAGE_DRAW_CTL_TRANSPARENT_EN.
- Defined: a ROM pixel equal to 12'hF0F (magenta key) is treated as transparent, and rgb_in_d is output instead.
- Not defined: every ROM pixel inside the sprite is drawn opaque.

Test Plan:
- Reset, show=1, xpos=100, ypos=50, first frame_tick -> at hcount_in=100, vcount_in=50, address=16'h0000 one cycle later; rgb_out=ROM[0] two cycles later.
- Same position with hcount_in=227, vcount_in=113 -> address=16'h3F7F. hcount_in=228 -> background pixel passes through with 2-cycle delay.
- show=1, blink=1, BLINK_FRAMES=2 -> visible pattern per frame 1,1,0,0,1,1. blink dropped -> visible=1 from the next frame_tick.
- xpos changed from 100 to 300 mid-frame -> current frame still drawn at 100; next frame drawn at 300.
- xpos=1000, IMG_W=128 with 1024-wide counters -> columns 1000..1023 drawn; no sprite pixels at column 0.
- Macro defined, ROM word 12'hF0F, rgb_in=12'h123 -> rgb_out=12'h123. Macro undefined -> rgb_out=12'hF0F. In either case, blanking forces rgb_out=12'h000.

Source files
------------

// File: rtl/image_draw_ctl.sv
// Sprite overlay stage: drives the image ROM address, delays VGA timing by two cycles and composites the sprite
// under a frame-synchronous hidden/shown/blink FSM. Define IMAGE_DRAW_CTL_TRANSPARENT_EN to key out 12'hF0F pixels.
module image_draw_ctl #(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 64,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        show,
    input  logic        blink,
    input  logic [11:0] rgb_pixel,
    output logic [15:0] address,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        visible
);
    typedef enum logic [1:0] {HIDDEN, SHOWN, BLINK} state_e;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } tmg_t;

    state_e      state_q, state_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d;
    logic        visible_q, visible_d;
    logic [11:0] x_lat_q, y_lat_q;
    logic        vblnk_prev_q;
    logic        frame_tick;

    tmg_t        tmg_in, s1_tmg_q, s2_tmg_q;
    logic [11:0] s1_rgb_q, s2_rgb_q, rgb_d;
    logic [15:0] s1_addr_q, addr_d;
    logic        s1_inside_q, inside_d;
    logic [12:0] h_ext, v_ext, x_ext, y_ext;

    // Position and mode are only sampled at the start of vertical blanking so a frame never tears.
    assign frame_tick = vblnk_in & ~vblnk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HIDDEN;
            blink_cnt_q  <= 8'd0;
            phase_q      <= 1'b0;
            visible_q    <= 1'b0;
            x_lat_q      <= 12'd0;
            y_lat_q      <= 12'd0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            visible_q    <= visible_d;
            vblnk_prev_q <= vblnk_in;
            if (frame_tick) begin
                x_lat_q <= xpos;
                y_lat_q <= ypos;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_tick) begin
            case (state_q)
                HIDDEN: if (show) begin
                    if (blink) begin
                        state_d     = BLINK;
                        blink_cnt_d = 8'd0;
                        phase_d     = 1'b1;
                    end else begin
                        state_d = SHOWN;
                    end
                end
                SHOWN: if (!show) begin
                    state_d = HIDDEN;
                end else if (blink) begin
                    state_d     = BLINK;
                    blink_cnt_d = 8'd0;
                    phase_d     = 1'b1;
                end
                BLINK: if (!show) begin
                    state_d = HIDDEN;
                end else if (!blink) begin
                    state_d = SHOWN;
                end else if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt_d = 8'd0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
                default: state_d = HIDDEN;
            endcase
        end
    end

    always_comb begin
        visible_d = visible_q;
        if (frame_tick)
            visible_d = (state_d == SHOWN) || ((state_d == BLINK) && phase_d);
    end

    // 13-bit compares keep a sprite hanging off the right/bottom edge from wrapping back to 0.
    assign tmg_in   = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    assign h_ext    = {2'b00, hcount_in};
    assign v_ext    = {2'b00, vcount_in};
    assign x_ext    = {1'b0, x_lat_q};
    assign y_ext    = {1'b0, y_lat_q};
    assign inside_d = (h_ext >= x_ext) && (h_ext < x_ext + 13'(IMG_W)) &&
                      (v_ext >= y_ext) && (v_ext < y_ext + 13'(IMG_H));
    assign addr_d   = inside_d ? {vcount_in[7:0] - y_lat_q[7:0], hcount_in[7:0] - x_lat_q[7:0]} : 16'h0000;

    always_comb begin
        rgb_d = s1_rgb_q;
        if (s1_tmg_q.hblnk || s1_tmg_q.vblnk) begin
            rgb_d = 12'h000;
        end else if (s1_inside_q && visible_q) begin
`ifdef IMAGE_DRAW_CTL_TRANSPARENT_EN
            if (rgb_pixel != 12'hF0F)
                rgb_d = rgb_pixel;
`else
            rgb_d = rgb_pixel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tmg_q    <= '0;
            s1_rgb_q    <= 12'h000;
            s1_addr_q   <= 16'h0000;
            s1_inside_q <= 1'b0;
            s2_tmg_q    <= '0;
            s2_rgb_q    <= 12'h000;
        end else begin
            s1_tmg_q    <= tmg_in;
            s1_rgb_q    <= rgb_in;
            s1_addr_q   <= addr_d;
            s1_inside_q <= inside_d;
            s2_tmg_q    <= s1_tmg_q;
            s2_rgb_q    <= rgb_d;
        end
    end

    assign address    = s1_addr_q;
    assign hcount_out = s2_tmg_q.hcount;
    assign vcount_out = s2_tmg_q.vcount;
    assign hsync_out  = s2_tmg_q.hsync;
    assign vsync_out  = s2_tmg_q.vsync;
    assign hblnk_out  = s2_tmg_q.hblnk;
    assign vblnk_out  = s2_tmg_q.vblnk;
    assign rgb_out    = s2_rgb_q;
    assign visible    = visible_q;
endmodule

// File: tb/tb_image_draw_ctl.sv
// Bench for image_draw_ctl: directed scenarios plus randomized frames checked against a frame-level reference model.
module tb_image_draw_ctl;
    localparam int W = 128, H = 64, BF = 2;

    logic        clk = 1'b0, rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos, rgb_pixel;
    logic        show, blink;
    logic [15:0] address;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, visible;
    logic [11:0] rgb_out;

    logic [11:0] rom_mem [0:65535];
    // Registered address plus combinational array read = data valid in the cycle after the address.
    assign rgb_pixel = rom_mem[address];

    always #5 clk = ~clk;

    image_draw_ctl #(.IMG_W(W), .IMG_H(H), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .show(show), .blink(blink),
        .rgb_pixel(rgb_pixel), .address(address), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .visible(visible)
    );

    int checks = 0, errors = 0;

    typedef struct {
        bit rst; int h, v; bit hs, vs, hb, vb; logic [11:0] rgb; bit ins; logic [15:0] a; bit vis;
    } rec_t;
    rec_t cur, prev;

    // Frame-level model: mode 0 hidden, 1 shown, 2 blinking for m_k frames so far.
    int m_x, m_y, m_mode, m_k;
    bit m_vprev, m_vis;

    logic [15:0] e_addr;
    logic [10:0] e_h, e_v;
    logic        e_hs, e_vs, e_hb, e_vb, e_vis;
    logic [11:0] e_rgb;

    function automatic logic [11:0] pix(rec_t p);
        logic [11:0] romv;
        romv = rom_mem[p.a];
        if (p.hb || p.vb) return 12'h000;
        if (!(p.ins && p.vis)) return p.rgb;
`ifdef IMAGE_DRAW_CTL_TRANSPARENT_EN
        if (romv == 12'hF0F) return p.rgb;
`endif
        return romv;
    endfunction

    task automatic step();
        rec_t r;
        r.rst = rst; r.h = int'(hcount_in); r.v = int'(vcount_in);
        r.hs = hsync_in; r.vs = vsync_in; r.hb = hblnk_in; r.vb = vblnk_in; r.rgb = rgb_in;
        if (rst) begin
            m_x = 0; m_y = 0; m_mode = 0; m_k = 0; m_vis = 0; m_vprev = 0;
            r.ins = 0; r.a = 16'h0;
        end else begin
            r.ins = (r.h >= m_x) && (r.h < m_x + W) && (r.v >= m_y) && (r.v < m_y + H);
            r.a = r.ins ? {8'(r.v - m_y), 8'(r.h - m_x)} : 16'h0;
            if (vblnk_in && !m_vprev) begin
                m_x = int'(xpos); m_y = int'(ypos);
                if (!show) m_mode = 0;
                else if (!blink) m_mode = 1;
                else begin
                    m_k = (m_mode == 2) ? m_k + 1 : 0;
                    m_mode = 2;
                end
                m_vis = (m_mode == 1) || (m_mode == 2 && ((m_k / BF) % 2 == 0));
            end
            m_vprev = vblnk_in;
        end
        r.vis = m_vis;
        prev = cur; cur = r;
        @(posedge clk); #1;
        e_addr = cur.a; e_vis = cur.vis;
        if (cur.rst || prev.rst) begin
            e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_rgb = 0;
        end else begin
            e_h = 11'(prev.h); e_v = 11'(prev.v); e_hs = prev.hs; e_vs = prev.vs;
            e_hb = prev.hb; e_vb = prev.vb; e_rgb = pix(prev);
        end
    endtask

    task automatic drive_px(input int h, input int v, input logic [11:0] rgb, input bit hb);
        hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = rgb;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom); hblnk_in = hb; vblnk_in = 1'b0;
        step();
    endtask

    task automatic frame_tick();
        hblnk_in = 1'b1; vblnk_in = 1'b1; hcount_in = 11'd0; vcount_in = 11'd0;
        step(); step();
        vblnk_in = 1'b0; hblnk_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_px(100, 50, 12'hABC, 0);
        drive_px(101, 50, 12'hABC, 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", address); end
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb_out); end
        checks++; if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== 26'd0) begin
            errors++; $display("FAIL reset_tmg got %h/%h exp 0", hcount_out, vcount_out); end
        checks++; if (visible !== 1'b0) begin errors++; $display("FAIL reset_vis got %b exp 0", visible); end
        rst = 1'b0;
    endtask

    task automatic test_basic_draw();
        logic [11:0] bg;
        show = 1; blink = 0; xpos = 100; ypos = 50;
        frame_tick();
        checks++; if (visible !== 1'b1) begin errors++; $display("FAIL basic_vis got %b exp 1", visible); end
        drive_px(100, 50, 12'($urandom), 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL basic_addr0 got %h exp 0000", address); end
        drive_px(101, 50, 12'($urandom), 0);
        checks++; if (rgb_out !== rom_mem[0]) begin errors++; $display("FAIL basic_rom0 got %h exp %h", rgb_out, rom_mem[0]); end
        checks++; if (hcount_out !== 11'd100) begin errors++; $display("FAIL basic_hlat got %0d exp 100", hcount_out); end
        drive_px(227, 113, 12'($urandom), 0);
        checks++; if (address !== 16'h3F7F) begin errors++; $display("FAIL basic_addr_last got %h exp 3F7F", address); end
        bg = 12'($urandom);
        drive_px(228, 113, bg, 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL basic_addr_past got %h exp 0000", address); end
        checks++; if (rgb_out !== rom_mem[16'h3F7F]) begin errors++; $display("FAIL basic_last_px got %h exp %h", rgb_out, rom_mem[16'h3F7F]); end
        drive_px(229, 113, 12'($urandom), 0);
        checks++; if (rgb_out !== bg) begin errors++; $display("FAIL basic_bg got %h exp %h", rgb_out, bg); end
        checks++; if (hcount_out !== 11'd228 || vcount_out !== 11'd113) begin
            errors++; $display("FAIL basic_cnt got %0d,%0d exp 228,113", hcount_out, vcount_out); end
        drive_px(150, 114, 12'($urandom), 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL basic_row_past got %h exp 0000", address); end
    endtask

    task automatic test_blink();
        logic [5:0] pat;
        logic [11:0] bg, exp_px;
        pat = 6'b110011;
        show = 1; blink = 1;
        for (int i = 0; i < 6; i++) begin
            frame_tick();
            checks++; if (visible !== pat[5-i]) begin errors++; $display("FAIL blink_vis[%0d] got %b exp %b", i, visible, pat[5-i]); end
            bg = 12'($urandom);
            drive_px(110, 60, bg, 0);
            drive_px(111, 60, 12'($urandom), 0);
            exp_px = pat[5-i] ? rom_mem[16'h0A0A] : bg;
            checks++; if (rgb_out !== exp_px) begin errors++; $display("FAIL blink_px[%0d] got %h exp %h", i, rgb_out, exp_px); end
        end
        blink = 0;
        frame_tick();
        checks++; if (visible !== 1'b1) begin errors++; $display("FAIL blink_drop got %b exp 1", visible); end
    endtask

    task automatic test_midframe_pos();
        xpos = 300;
        drive_px(100, 60, 12'($urandom), 0);
        checks++; if (address !== 16'h0A00) begin errors++; $display("FAIL mid_old_pos got %h exp 0A00", address); end
        drive_px(300, 60, 12'($urandom), 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL mid_new_early got %h exp 0000", address); end
        frame_tick();
        drive_px(300, 60, 12'($urandom), 0);
        checks++; if (address !== 16'h0A00) begin errors++; $display("FAIL mid_new_pos got %h exp 0A00", address); end
        drive_px(100, 60, 12'($urandom), 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL mid_old_gone got %h exp 0000", address); end
    endtask

    task automatic test_offscreen();
        logic [11:0] bg;
        xpos = 1000; ypos = 0;
        frame_tick();
        drive_px(1023, 5, 12'($urandom), 0);
        checks++; if (address !== 16'h0517) begin errors++; $display("FAIL off_lastcol got %h exp 0517", address); end
        bg = 12'($urandom);
        drive_px(0, 5, bg, 0);
        checks++; if (address !== 16'h0000) begin errors++; $display("FAIL off_col0_addr got %h exp 0000", address); end
        drive_px(1, 5, 12'($urandom), 0);
        checks++; if (rgb_out !== bg) begin errors++; $display("FAIL off_col0_px got %h exp %h", rgb_out, bg); end
        drive_px(1000, 0, 12'($urandom), 0);
        drive_px(1001, 0, 12'($urandom), 0);
        checks++; if (rgb_out !== rom_mem[0]) begin errors++; $display("FAIL off_first got %h exp %h", rgb_out, rom_mem[0]); end
    endtask

    task automatic test_transparent();
        logic [11:0] exp_t;
`ifdef IMAGE_DRAW_CTL_TRANSPARENT_EN
        exp_t = 12'h123;
`else
        exp_t = 12'hF0F;
`endif
        drive_px(1002, 1, 12'h123, 0);
        drive_px(1003, 1, 12'h456, 0);
        checks++; if (rgb_out !== exp_t) begin errors++; $display("FAIL key_px got %h exp %h", rgb_out, exp_t); end
        drive_px(1002, 1, 12'h123, 1);
        drive_px(1003, 1, 12'h456, 0);
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL key_blank got %h exp 000", rgb_out); end
        drive_px(1010, 2, 12'h777, 1);
        drive_px(1011, 2, 12'h456, 0);
        checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL hblank_px got %h exp 000", rgb_out); end
    endtask

    task automatic test_midframe_reset();
        logic [11:0] bg;
        drive_px(1005, 3, 12'($urandom), 0);
        rst = 1'b1;
        drive_px(1006, 3, 12'($urandom), 0);
        checks++; if (address !== 16'h0000 || rgb_out !== 12'h000 || hcount_out !== 11'd0) begin
            errors++; $display("FAIL rst_mid got %h/%h/%0d exp 0/0/0", address, rgb_out, hcount_out); end
        checks++; if (visible !== 1'b0) begin errors++; $display("FAIL rst_mid_vis got %b exp 0", visible); end
        rst = 1'b0;
        bg = 12'($urandom);
        drive_px(5, 5, bg, 0);
        checks++; if (address !== 16'h0505) begin errors++; $display("FAIL rst_addr got %h exp 0505", address); end
        drive_px(6, 5, 12'($urandom), 0);
        checks++; if (visible !== 1'b0 || rgb_out !== bg) begin
            errors++; $display("FAIL rst_hidden got vis %b rgb %h exp 0 %h", visible, rgb_out, bg); end
        show = 1; blink = 0;
        frame_tick();
        checks++; if (visible !== 1'b1) begin errors++; $display("FAIL rst_reshow got %b exp 1", visible); end
    endtask

    task automatic test_random();
        int x, y, h, v;
        for (int f = 0; f < 12; f++) begin
            xpos = 12'($urandom_range(1100)); ypos = 12'($urandom_range(600));
            show = ($urandom_range(3) != 0); blink = ($urandom_range(2) == 0);
            x = int'(xpos); y = int'(ypos);
            frame_tick();
            for (int i = 0; i < 80; i++) begin
                if (i == 40) xpos = 12'($urandom_range(1100));
                h = x - 4 + int'($urandom_range(W + 8)); v = y - 4 + int'($urandom_range(H + 8));
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                if (h > 2047) h = 2047;
                drive_px(h, v, 12'($urandom), ($urandom_range(15) == 0));
                checks++;
                if ({address, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, visible} !==
                    {e_addr, e_h, e_v, e_hs, e_vs, e_hb, e_vb, e_rgb, e_vis}) begin
                    errors++;
                    $display("FAIL rnd f%0d i%0d got a=%h h=%0d v=%0d rgb=%h vis=%b exp a=%h h=%0d v=%0d rgb=%h vis=%b",
                             f, i, address, hcount_out, vcount_out, rgb_out, visible, e_addr, e_h, e_v, e_rgb, e_vis);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 12'($urandom);
        rom_mem[16'h0102] = 12'hF0F;
        rst = 1'b1; hcount_in = 0; vcount_in = 0; hsync_in = 0; vsync_in = 0;
        hblnk_in = 0; vblnk_in = 0; rgb_in = 0; xpos = 0; ypos = 0; show = 0; blink = 0;
        cur = '{rst: 1'b1, default: 0};
        prev = cur;
        test_reset();
        test_basic_draw();
        test_blink();
        test_midframe_pos();
        test_offscreen();
        test_transparent();
        test_midframe_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
